// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the Execute stage and the multiply/divide unit.
//
// Signals:
//   start  - request pulse, honoured only while the unit is idle
//   flush  - abort whatever the unit is doing (branch/jump flush of E)
//   funct3 - RV32M operation select (MUL .. REMU)
//   srca   - rs1 operand
//   srcb   - rs2 operand
//   busy   - iteration in progress; E-stage stall source
//   done   - one-cycle result-valid pulse
//   result - operation result, held until the next completed operation
//
// Modports: master drives the request (pipeline side), slave is the unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, srca, srcb,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, srca, srcb,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit.
//
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - muldiv_unit_if slave: start/flush/funct3/srca/srcb in, busy/done/result out
//
// Multiplies run a radix-2 shift-add over 32 cycles, divides a restoring division over
// 32 cycles, both on operand magnitudes with a sign fix-up when the result is formed.
// Divide-by-zero and signed overflow bypass the iteration and complete immediately.
//
// Optional build macro MULDIV_FAST_MUL_EN: multiplies are computed combinationally at
// start and go straight to DONE (busy never asserts for them); divides are unchanged.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6    // 2**CNT_W must exceed XLEN
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  localparam logic [XLEN-1:0]  AllOnes = '1;
  localparam logic [XLEN-1:0]  MinInt  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(XLEN - 1);

  state_e            state_q;
  logic [2:0]        f3_q;
  logic              neg_q;      // negate product / quotient
  logic              neg_rem_q;  // negate remainder
  logic [2*XLEN-1:0] acc_q;      // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opb_q;      // mul: |multiplicand|; div: |divisor|
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  // Operand decode for the request currently presented.
  logic            a_signed, b_signed, sign_a, sign_b, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b;

  always_comb begin
    if (bus.funct3[2]) begin
      a_signed = ~bus.funct3[0];
      b_signed = ~bus.funct3[0];
    end else begin
      a_signed = (bus.funct3[1:0] != 2'b11);  // MULHU is the only unsigned-rs1 multiply
      b_signed = ~bus.funct3[1];              // MULHSU/MULHU treat rs2 as unsigned
    end
    sign_a   = a_signed & bus.srca[XLEN-1];
    sign_b   = b_signed & bus.srcb[XLEN-1];
    abs_a    = sign_a ? ('0 - bus.srca) : bus.srca;
    abs_b    = sign_b ? ('0 - bus.srcb) : bus.srcb;
    div_zero = (bus.srcb == '0);
    div_ovf  = ~bus.funct3[0] & (bus.srca == MinInt) & (bus.srcb == AllOnes);
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extending to 2*XLEN and keeping the low 2*XLEN bits of the product is the same as
  // a signed (XLEN+1)x(XLEN+1) multiply truncated to 2*XLEN.
  logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;

  always_comb begin
    ext_a     = {{XLEN{sign_a}}, bus.srca};
    ext_b     = {{XLEN{sign_b}}, bus.srcb};
    fast_prod = ext_a * ext_b;
  end
`endif

  // One iteration of each algorithm.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    // Shift the next dividend bit into the partial remainder, subtract when it fits.
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_sub   = div_shift[XLEN-1:0] - opb_q;  // exact: true difference is below the divisor
    div_next  = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                       : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // Sign fix-up and result selection.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  always_comb begin
    prod_fix = neg_q ? ('0 - acc_q) : acc_q;
    quo_fix  = neg_q ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    case (f3_q)
      3'b000:                final_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_fix;
      default:                final_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // While done is high the pipeline still presents the completing instruction's
          // start; it must not be taken as a new request.
          if (bus.start && !bus.flush && !done_q) begin
            f3_q  <= bus.funct3;
            cnt_q <= '0;
            if (!bus.funct3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
              acc_q     <= fast_prod;
              opb_q     <= '0;
              neg_q     <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= StDone;
`else
              acc_q     <= {{XLEN{1'b0}}, abs_b};
              opb_q     <= abs_a;
              neg_q     <= sign_a ^ sign_b;
              neg_rem_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= StMul;
`endif
            end else if (div_zero) begin
              acc_q     <= {bus.srca, AllOnes};
              opb_q     <= '0;
              neg_q     <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= StDone;
            end else if (div_ovf) begin
              acc_q     <= {{XLEN{1'b0}}, MinInt};
              opb_q     <= '0;
              neg_q     <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= StDone;
            end else begin
              acc_q     <= {{XLEN{1'b0}}, abs_a};
              opb_q     <= abs_b;
              neg_q     <= sign_a ^ sign_b;
              neg_rem_q <= sign_a;
              busy_q    <= 1'b1;
              state_q   <= StDiv;
            end
          end
        end
        StMul, StDiv: begin
          if (bus.flush) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q <= (state_q == StMul) ? mul_next : div_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              busy_q  <= 1'b0;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          if (!bus.flush) begin
            done_q   <= 1'b1;
            result_q <= final_res;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected results are queued when a request is
// issued and popped when the unit raises done.
module tb_muldiv_unit;
  localparam int unsigned XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // Reference results from plain language arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (f3)
      3'b000: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[31:0]; end
      3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      3'b010: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'b100: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    if (!f3[2] && FastMul) return 1;
    return 33;
  endfunction

  // Drive a start for one clock edge (edge 0 of the operation).
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.funct3 = f3;
    bus.srca   = a;
    bus.srcb   = b;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Watch cycles after the issuing edge until done; cycle 0 is the one right after it.
  task automatic wait_done(output logic [31:0] res, output int lat, output int nbusy,
                           output bit seen);
    res = '0; lat = -1; nbusy = 0; seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.done) begin
        res = bus.result; lat = c; seen = 1'b1;
        bus.start = 1'b0;
        break;
      end
      if (bus.busy) nbusy++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.flush = 1'b1;
    bus.funct3 = 3'b100; bus.srca = 32'd100; bus.srcb = 32'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
    bus.start = 1'b0; bus.flush = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  f3s[4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] as[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs[4]  = '{32'h3, 32'h3, 32'h3, 32'hFFFF_FFFF};
    logic [31:0] ex[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    logic [31:0] res, e;
    int lat, nb, el;
    bit seen;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ex[i]);
      el = exp_lat(f3s[i], as[i], bs[i]);
      issue(f3s[i], as[i], bs[i]);
      wait_done(res, lat, nb, seen);
      e = exp_q.pop_front();
      n_tests++; if (!seen || res !== e) begin n_fail++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, e); end
      n_tests++; if (lat != el) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, el); end
      n_tests++; if (nb != ((el == 33) ? 32 : 0)) begin
        n_fail++; $display("FAIL mul_busy_cycles[%0d]: got %0d want %0d", i, nb, (el == 33) ? 32 : 0);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3s[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
    logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'd2, 32'd2};
    logic [31:0] ex[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3, 32'd1};
    logic [31:0] res, e;
    int lat, nb;
    bit seen;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ex[i]);
      issue(f3s[i], as[i], bs[i]);
      wait_done(res, lat, nb, seen);
      e = exp_q.pop_front();
      n_tests++; if (!seen || res !== e) begin n_fail++; $display("FAIL div_result[%0d]: got %h want %h", i, res, e); end
      n_tests++; if (lat != 33 || nb != 32) begin
        n_fail++; $display("FAIL div_timing[%0d]: latency %0d busy %0d want 33/32", i, lat, nb);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3s[4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] as[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex[4]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    logic [31:0] res, e;
    int lat, nb;
    bit seen;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ex[i]);
      issue(f3s[i], as[i], bs[i]);
      wait_done(res, lat, nb, seen);
      e = exp_q.pop_front();
      n_tests++; if (!seen || res !== e) begin n_fail++; $display("FAIL special_result[%0d]: got %h want %h", i, res, e); end
      n_tests++; if (lat != 1 || nb != 0) begin
        n_fail++; $display("FAIL special_timing[%0d]: latency %0d busy %0d want 1/0", i, lat, nb);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res, e;
    logic [2:0]  op;
    int lat, nb, nd;
    bit seen;
    exp_q.push_back(32'd42);
    issue(3'b000, 32'd6, 32'd7);
    wait_done(res, lat, nb, seen);
    e = exp_q.pop_front();
    n_tests++; if (!seen || res !== e) begin n_fail++; $display("FAIL flush_setup: got %h want %h", res, e); end
    // A fast-multiply build has no iterative multiply to abort, so use a divide there.
    op = FastMul ? 3'b101 : 3'b000;
    issue(op, 32'h1234_5678, 32'h0000_9ABC);
    repeat (6) @(negedge clk);
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b want 1", bus.busy); end
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle: busy got %b want 0", bus.busy); end
    nd = 0;
    repeat (40) begin @(negedge clk); if (bus.done) nd++; end
    n_tests++; if (nd != 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses want 0", nd); end
    n_tests++; if (bus.result !== 32'd42) begin n_fail++; $display("FAIL flush_result_held: got %h want 0000002a", bus.result); end
    // start together with flush while idle is dropped
    @(negedge clk);
    bus.funct3 = 3'b101; bus.srca = 32'd9; bus.srcb = 32'd3;
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
    nd = 0; nb = 0;
    repeat (40) begin @(negedge clk); if (bus.done) nd++; if (bus.busy) nb++; end
    n_tests++; if (nd != 0 || nb != 0) begin
      n_fail++; $display("FAIL flush_start_dropped: done %0d busy %0d want 0/0", nd, nb);
    end
    n_tests++; if (bus.result !== 32'd42) begin n_fail++; $display("FAIL flush_start_result: got %h want 0000002a", bus.result); end
  endtask

  task automatic test_busy_start();
    logic [31:0] res, e;
    int lat, nb, nb2;
    bit seen;
    exp_q.push_back(model(3'b101, 32'd1000, 32'd7));
    issue(3'b101, 32'd1000, 32'd7);
    repeat (3) @(negedge clk);
    // Competing request held while busy; operands must not be re-latched.
    bus.funct3 = 3'b000; bus.srca = 32'd5; bus.srcb = 32'd5; bus.start = 1'b1;
    wait_done(res, lat, nb, seen);
    e = exp_q.pop_front();
    n_tests++; if (!seen || res !== e) begin n_fail++; $display("FAIL busy_start_result: got %h want %h", res, e); end
    n_tests++; if (lat + 3 != 33) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 33", lat + 3); end
    nb2 = 0;
    repeat (4) begin @(negedge clk); if (bus.busy || bus.done) nb2++; end
    n_tests++; if (nb2 != 0) begin n_fail++; $display("FAIL busy_start_no_restart: got %0d active cycles want 0", nb2); end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] res, e;
    int lat, nb;
    bit seen;
    issue(3'b100, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b want 0", bus.done); end
    n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL midreset_result: got %h want 0", bus.result); end
    exp_q.push_back(32'd14);
    issue(3'b100, 32'd100, 32'd7);
    wait_done(res, lat, nb, seen);
    e = exp_q.pop_front();
    n_tests++; if (!seen || res !== e || lat != 33) begin
      n_fail++; $display("FAIL midreset_rerun: got %h at %0d want %h at 33", res, lat, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res, e, a, b;
    logic [2:0]  f3;
    int lat, nb, el;
    bit seen;
    for (int i = 0; i < 24; i++) begin
      f3 = 3'(i);
      a  = $urandom;
      b  = (i % 3 == 1) ? $urandom_range(1, 50) : $urandom;
      if (i == 12) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (i == 13 || i == 7) b = 32'h0;
      exp_q.push_back(model(f3, a, b));
      el = exp_lat(f3, a, b);
      issue(f3, a, b);
      wait_done(res, lat, nb, seen);
      e = exp_q.pop_front();
      n_tests++; if (!seen || res !== e) begin
        n_fail++; $display("FAIL b2b_result[%0d] f3=%0d a=%h b=%h: got %h want %h", i, f3, a, b, res, e);
      end
      n_tests++; if (lat != el) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, el); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.srca = '0; bus.srcb = '0;
    reset = 1'b1;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_busy_start();
    test_reset_mid_div();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
